// File: rtl/axil_uart_tx.sv
// AXI4-Lite slave UART transmitter: register writes fill a TX FIFO that is
// serialized 8N1, LSB first, onto tx_o.
module axil_uart_tx #(
   parameter int CLKS_PER_BIT = 868,
   parameter int FIFO_DEPTH   = 16
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [3:0]  s_axi_awaddr_i,
   input  logic        s_axi_awvalid_i,
   output logic        s_axi_awready_o,
   input  logic [31:0] s_axi_wdata_i,
   input  logic [3:0]  s_axi_wstrb_i,
   input  logic        s_axi_wvalid_i,
   output logic        s_axi_wready_o,
   output logic [1:0]  s_axi_bresp_o,
   output logic        s_axi_bvalid_o,
   input  logic        s_axi_bready_i,
   input  logic [3:0]  s_axi_araddr_i,
   input  logic        s_axi_arvalid_i,
   output logic        s_axi_arready_o,
   output logic [31:0] s_axi_rdata_o,
   output logic [1:0]  s_axi_rresp_o,
   output logic        s_axi_rvalid_o,
   input  logic        s_axi_rready_i,
   output logic        tx_o
);
   localparam int BW = $clog2(CLKS_PER_BIT);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [PW:0]   FULL_CNT  = (PW+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   logic [7:0]    mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PW:0]   count_q, count_d;
   logic          bvalid_q, bvalid_d, rvalid_q, rvalid_d;
   logic [31:0]   rdata_q, rdata_d;
   state_t        state_q, state_d;
   logic [BW-1:0] baud_q, baud_d;
   logic [2:0]    idx_q, idx_d;
   logic [7:0]    shift_q, shift_d;
   logic          tx_q, tx_d;

   logic wr_hs, rd_hs, fifo_empty, fifo_full, push, pop, clr, bit_end;
   logic unused_bits;

   assign unused_bits = ^{s_axi_awaddr_i[1:0], s_axi_araddr_i[1:0],
                          s_axi_wdata_i[31:8], s_axi_wstrb_i[3:1]};

   // Ready is combinational so a handshake completes in the cycle both valids meet.
   assign wr_hs      = s_axi_awvalid_i && s_axi_wvalid_i && !bvalid_q && !rst_i;
   assign rd_hs      = s_axi_arvalid_i && !rvalid_q && !rst_i;
   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == FULL_CNT);
   assign push       = wr_hs && (s_axi_awaddr_i[3:2] == 2'd1) && s_axi_wstrb_i[0] && !fifo_full;
   assign clr        = wr_hs && (s_axi_awaddr_i[3:2] == 2'd3) && s_axi_wdata_i[0];
   assign bit_end    = (baud_q == BAUD_LAST);

   assign s_axi_awready_o = wr_hs;
   assign s_axi_wready_o  = wr_hs;
   assign s_axi_arready_o = rd_hs;
   assign s_axi_bvalid_o  = bvalid_q;
   assign s_axi_bresp_o   = 2'b00;
   assign s_axi_rvalid_o  = rvalid_q;
   assign s_axi_rdata_o   = rdata_q;
   assign s_axi_rresp_o   = 2'b00;
   assign tx_o            = tx_q;

   always_comb begin
      bvalid_d = bvalid_q ? !s_axi_bready_i : wr_hs;
      rvalid_d = rvalid_q ? !s_axi_rready_i : rd_hs;
      rdata_d  = rdata_q;
      if (rd_hs) begin
         rdata_d = '0;
         if (s_axi_araddr_i[3:2] == 2'd2)
            rdata_d = {28'd0, fifo_full, fifo_empty, 2'b00};
      end
   end

   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      tx_d    = tx_q;
      pop     = 1'b0;
      if (state_q != S_IDLE)
         baud_d = bit_end ? '0 : baud_q + BW'(1);
      case (state_q)
         S_IDLE: begin
            tx_d = 1'b1;
            if (!fifo_empty) begin
               pop     = 1'b1;
               shift_d = mem[rd_ptr_q];
               state_d = S_START;
               baud_d  = '0;
               tx_d    = 1'b0;
            end
         end
         S_START: begin
            if (bit_end) begin
               state_d = S_DATA;
               idx_d   = 3'd0;
               tx_d    = shift_q[0];
            end
         end
         S_DATA: begin
            if (bit_end) begin
               if (idx_q == 3'd7) begin
                  state_d = S_STOP;
                  tx_d    = 1'b1;
               end else begin
                  idx_d = idx_q + 3'd1;
                  tx_d  = shift_q[idx_q + 3'd1];
               end
            end
         end
         default: begin
            // Chain straight into the next start bit when more data is queued.
            if (bit_end) begin
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  shift_d = mem[rd_ptr_q];
                  state_d = S_START;
                  tx_d    = 1'b0;
               end else begin
                  state_d = S_IDLE;
                  tx_d    = 1'b1;
               end
            end
         end
      endcase
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clr) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push)
            wr_ptr_d = wr_ptr_q + PW'(1);
         if (pop)
            rd_ptr_d = rd_ptr_q + PW'(1);
         if (push && !pop)
            count_d = count_q + (PW+1)'(1);
         else if (pop && !push)
            count_d = count_q - (PW+1)'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (push)
         mem[wr_ptr_q] <= s_axi_wdata_i[7:0];
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         bvalid_q <= 1'b0;
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
         state_q  <= S_IDLE;
         baud_q   <= '0;
         idx_q    <= '0;
         shift_q  <= '0;
         tx_q     <= 1'b1;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         bvalid_q <= bvalid_d;
         rvalid_q <= rvalid_d;
         rdata_q  <= rdata_d;
         state_q  <= state_d;
         baud_q   <= baud_d;
         idx_q    <= idx_d;
         shift_q  <= shift_d;
         tx_q     <= tx_d;
      end
   end

endmodule

// File: tb/tb_axil_uart_tx.sv
// Directed bench for axil_uart_tx: register accesses over AXI-Lite and a
// per-cycle log of tx_o compared against hand-built 8N1 frames.
module tb_axil_uart_tx;
   localparam int CPB    = 4;
   localparam int DEPTH  = 4;
   localparam int LINE_N = 4096;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  awaddr, araddr;
   logic        awvalid, wvalid, bready, arvalid, rready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        awready, wready, bvalid, arready, rvalid, tx;
   logic [1:0]  bresp, rresp;
   logic [31:0] rdata;

   axil_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
      .clk_i(clk), .rst_i(rst),
      .s_axi_awaddr_i(awaddr), .s_axi_awvalid_i(awvalid), .s_axi_awready_o(awready),
      .s_axi_wdata_i(wdata), .s_axi_wstrb_i(wstrb), .s_axi_wvalid_i(wvalid),
      .s_axi_wready_o(wready), .s_axi_bresp_o(bresp), .s_axi_bvalid_o(bvalid),
      .s_axi_bready_i(bready), .s_axi_araddr_i(araddr), .s_axi_arvalid_i(arvalid),
      .s_axi_arready_o(arready), .s_axi_rdata_o(rdata), .s_axi_rresp_o(rresp),
      .s_axi_rvalid_o(rvalid), .s_axi_rready_i(rready), .tx_o(tx)
   );

   always #5 clk = ~clk;

   int   cyc = 0;
   logic line [LINE_N];
   int   checks = 0;
   int   failures = 0;

   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (cyc < LINE_N) line[cyc] = tx;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [39:0] exp_frame(input logic [7:0] b);
      logic [39:0] f;
      for (int i = 0; i < 40; i++) begin
         if (i / CPB == 0)      f[i] = 1'b0;
         else if (i / CPB == 9) f[i] = 1'b1;
         else                   f[i] = b[i / CPB - 1];
      end
      return f;
   endfunction

   task automatic check_frame(input string tag, input int start, input logic [7:0] b);
      logic [39:0] obs;
      while (cyc <= start + 41) @(negedge clk);
      for (int i = 0; i < 40; i++)
         obs[i] = (start + i < LINE_N && start + i >= 0) ? line[start + i] : 1'bx;
      check(tag, 64'(obs), 64'(exp_frame(b)));
   endtask

   task automatic check_idle(input string tag, input int from, input int n);
      logic all_high;
      while (cyc <= from + n) @(negedge clk);
      all_high = 1'b1;
      for (int i = from; i < from + n; i++)
         if (i < 0 || i >= LINE_N || line[i] !== 1'b1) all_high = 1'b0;
      check(tag, 64'(all_high), 64'(1));
   endtask

   task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int bstall, output int hs);
      int   n;
      logic held;
      awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
      bready = (bstall == 0);
      n = 0; hs = -1;
      #1;
      while (!(awready && wready) && n < 100) begin
         @(negedge clk); #1; n++;
      end
      if (n >= 100) begin
         check("wr_timeout", 64'(0), 64'(1));
         awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
         return;
      end
      hs = cyc;
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0;
      check("bvalid_rise", 64'(bvalid), 64'(1));
      check("bresp", 64'(bresp), 64'(0));
      if (bstall > 0) begin
         held = 1'b1;
         repeat (bstall) begin
            @(negedge clk);
            if (!bvalid || bresp !== 2'b00) held = 1'b0;
         end
         check("bvalid_held", 64'(held), 64'(1));
         bready = 1'b1;
      end
      @(negedge clk);
      check("bvalid_fall", 64'(bvalid), 64'(0));
   endtask

   task automatic axi_read(input logic [3:0] a, input int rstall, output logic [31:0] d);
      int   n;
      logic stable;
      araddr = a; arvalid = 1'b1; rready = 1'b0;
      n = 0; d = '1;
      #1;
      while (!arready && n < 100) begin
         @(negedge clk); #1; n++;
      end
      if (n >= 100) begin
         check("rd_timeout", 64'(0), 64'(1));
         arvalid = 1'b0;
         return;
      end
      @(negedge clk);
      arvalid = 1'b0;
      check("rvalid_rise", 64'(rvalid), 64'(1));
      check("rresp", 64'(rresp), 64'(0));
      d = rdata;
      if (rstall > 0) begin
         stable = 1'b1;
         repeat (rstall) begin
            @(negedge clk);
            if (!rvalid || rdata !== d) stable = 1'b0;
         end
         check("rdata_stable", 64'(stable), 64'(1));
      end
      rready = 1'b1;
      @(negedge clk);
      rready = 1'b0;
      check("rvalid_fall", 64'(rvalid), 64'(0));
   endtask

   initial begin
      int          h, h1, h2, h3, t0, rc;
      logic [31:0] d;
      logic        acc;
      rst = 1'b1; awaddr = '0; araddr = '0; awvalid = 1'b0; wvalid = 1'b0;
      bready = 1'b1; arvalid = 1'b0; rready = 1'b0; wdata = '0; wstrb = '0;
      repeat (3) @(negedge clk);
      check("rst_tx", 64'(tx), 64'(1));
      check("rst_valids", 64'({awready, wready, bvalid, arready, rvalid}), 64'(0));
      check("rst_resp_rdata", 64'({bresp, rresp, rdata}), 64'(0));
      rst = 1'b0;
      t0 = cyc;

      // Reset state and quiet line
      axi_read(4'h8, 0, d);
      check("status_reset", 64'(d), 64'h4);
      check_idle("idle_100", t0, 100);

      // Single frame timing
      axi_write(4'h4, 32'h0000_00A5, 4'h1, 0, h);
      check_frame("frame_a5", h + 2, 8'hA5);
      check("a5_pre_start", 64'(line[h + 1]), 64'(1));
      check_idle("a5_after", h + 42, 10);

      // Back-to-back frames
      axi_write(4'h4, 32'h41, 4'h1, 0, h1);
      axi_write(4'h4, 32'h42, 4'h1, 0, h2);
      axi_write(4'h4, 32'h43, 4'h1, 0, h3);
      check("b2b_accept", 64'({h2 - h1, h3 - h1}), 64'({32'd2, 32'd4}));
      axi_read(4'h8, 0, d);
      check("status_two_queued", 64'(d), 64'h0);
      check_frame("frame_41", h1 + 2, 8'h41);
      check_frame("frame_42", h1 + 42, 8'h42);
      check_frame("frame_43", h1 + 82, 8'h43);
      axi_read(4'h8, 0, d);
      check("status_drained", 64'(d), 64'h4);

      // Overflow with a depth-4 FIFO
      axi_write(4'h4, 32'h10, 4'h1, 0, h1);
      axi_write(4'h4, 32'h11, 4'h1, 0, h);
      axi_write(4'h4, 32'h12, 4'h1, 0, h);
      axi_write(4'h4, 32'h13, 4'h1, 0, h);
      axi_write(4'h4, 32'h14, 4'h1, 0, h);
      axi_read(4'h8, 0, d);
      check("status_full", 64'(d), 64'h8);
      axi_read(4'h4, 0, d);
      check("tx_reg_reads_0", 64'(d), 64'h0);
      axi_write(4'h4, 32'h15, 4'h1, 0, h);
      check_frame("ovf_frame0", h1 + 2, 8'h10);
      check_frame("ovf_frame1", h1 + 42, 8'h11);
      check_frame("ovf_frame2", h1 + 82, 8'h12);
      check_frame("ovf_frame3", h1 + 122, 8'h13);
      check_frame("ovf_frame4", h1 + 162, 8'h14);
      check_idle("ovf_dropped", h1 + 202, 60);

      // Strobe low means no push
      axi_write(4'h4, 32'h77, 4'hE, 0, h);
      check_idle("strb0_no_push", h, 60);

      // CTRL clear while a frame is on the line
      axi_write(4'h4, 32'h31, 4'h1, 0, h1);
      axi_write(4'h4, 32'h32, 4'h1, 0, h);
      axi_write(4'h4, 32'h33, 4'h1, 0, h);
      axi_write(4'hC, 32'h1, 4'hF, 0, h);
      check_frame("clr_frame", h1 + 2, 8'h31);
      check_idle("clr_no_more", h1 + 42, 60);
      axi_read(4'h8, 0, d);
      check("status_cleared", 64'(d), 64'h4);

      // AW early, W early, B and R back-pressure
      awaddr = 4'h8; awvalid = 1'b1; wvalid = 1'b0; bready = 1'b0;
      acc = 1'b0;
      repeat (3) begin
         @(negedge clk); #1;
         if (awready || wready) acc = 1'b1;
      end
      check("aw_only_wait", 64'(acc), 64'(0));
      awvalid = 1'b0; wvalid = 1'b1;
      acc = 1'b0;
      repeat (2) begin
         @(negedge clk); #1;
         if (awready || wready) acc = 1'b1;
      end
      check("w_only_wait", 64'(acc), 64'(0));
      @(negedge clk);
      axi_write(4'h8, 32'hFFFF_FFFF, 4'hF, 5, h);
      axi_read(4'h8, 4, d);
      check("status_stalled_read", 64'(d), 64'h4);

      // Reset mid-frame with a read response pending
      axi_write(4'h4, 32'h00, 4'h1, 0, h);
      axi_write(4'h4, 32'h55, 4'h1, 0, h2);
      while (cyc < h + 14) @(negedge clk);
      araddr = 4'h8; arvalid = 1'b1; rready = 1'b0;
      @(negedge clk);
      arvalid = 1'b0;
      rst = 1'b1;
      rc = cyc;
      @(negedge clk);
      check("pre_rst_low", 64'(line[rc]), 64'(0));
      check("rst_tx_high", 64'(tx), 64'(1));
      check("rst_mid_valids", 64'({awready, wready, bvalid, arready, rvalid}), 64'(0));
      rst = 1'b0;
      check_idle("rst_fifo_lost", rc + 1, 80);
      axi_read(4'h8, 0, d);
      check("status_after_rst", 64'(d), 64'h4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/axil_uart_tx.md
# axil_uart_tx

AXI4-Lite slave UART transmitter that sits directly downstream of the CPU's AXI-Lite bus master, in place of the vendor UART IP. It keeps the same 4-bit register map, so firmware is unchanged. Bytes the core writes are buffered in a TX FIFO, then serialized 8N1, LSB first, onto `tx_o`. There is no receive path.

## Interface
Parameters:
- `CLKS_PER_BIT`, 868: clock cycles per UART bit (100 MHz / 115200); legal range ≥ 2.
- `FIFO_DEPTH`, 16: TX FIFO entries; must be a power of two, ≥ 2.

Ports (one clock `clk_i`; reset `rst_i` is synchronous, active-high):
- `clk_i` in 1: system clock.
- `rst_i` in 1: synchronous active-high reset.
- `s_axi_awaddr_i` in 4: write address, byte offset.
- `s_axi_awvalid_i` in 1 / `s_axi_awready_o` out 1: AW handshake.
- `s_axi_wdata_i` in 32: write data.
- `s_axi_wstrb_i` in 4: byte strobes.
- `s_axi_wvalid_i` in 1 / `s_axi_wready_o` out 1: W handshake.
- `s_axi_bresp_o` out 2, `s_axi_bvalid_o` out 1, `s_axi_bready_i` in 1: write response.
- `s_axi_araddr_i` in 4: read address.
- `s_axi_arvalid_i` in 1 / `s_axi_arready_o` out 1: AR handshake.
- `s_axi_rdata_o` out 32, `s_axi_rresp_o` out 2, `s_axi_rvalid_o` out 1, `s_axi_rready_i` in 1: read data.
- `tx_o` out 1: UART serial output; idles high.

## Operation
- Register map (decode uses `addr[3:2]`):
  - 0x0 RX: reads 0.
  - 0x4 TX: write-only; reads 0.
  - 0x8 STATUS: read-only.
    - bit2: TX FIFO empty.
    - bit3: TX FIFO full.
    - All other bits read 0.
  - 0xC CTRL: write-only; reads 0. Writing bit0=1 clears the TX FIFO; all other bits are ignored.
- Write to 0x4 with `wstrb[0]`=1 and FIFO not full: `wdata[7:0]` is pushed.
  - If the FIFO is full, the byte is silently dropped.
  - `wstrb[0]`=0 means no push.
- Every write responds `bresp`=00 (OKAY), including writes to unmapped or read-only offsets. Every read responds `rresp`=00.
- Write channel:
  - `awready_o` and `wready_o` pulse high together for exactly one cycle, when `awvalid_i` and `wvalid_i` are both high and `bvalid_o` is low.
  - The register side effect happens on that handshake cycle.
  - AW-only or W-only presentation waits and is not accepted.
- Read channel:
  - `arready_o` pulses one cycle when `arvalid_i` is high and `rvalid_o` is low.
  - `rdata_o` is captured from state on that cycle.
- "Full" is the registered FIFO count before any same-cycle pop. A push in the same cycle as a pop of a full FIFO is dropped.
- CTRL FIFO clear empties the FIFO next cycle. A frame already in the shifter completes normally.
- TX FSM states:
  - IDLE: `tx_o`=1. If the FIFO is not empty, pop the head into the shift register and go to START.
  - START: `tx_o`=0 for `CLKS_PER_BIT` cycles, then go to DATA with bit index 0.
  - DATA: `tx_o`=shift[idx] for `CLKS_PER_BIT` cycles each, idx 0..7. After idx 7, go to STOP.
  - STOP: `tx_o`=1 for `CLKS_PER_BIT` cycles. At the last cycle, if the FIFO is not empty, pop and go to START (no idle gap); otherwise go to IDLE.
- Baud counter counts 0..`CLKS_PER_BIT`-1 and reloads to 0 on every bit boundary and state change. Its width is `$clog2(CLKS_PER_BIT)`. The bit index is 3 bits.
- FIFO pointers are `$clog2(FIFO_DEPTH)` bits and wrap naturally. The count is one bit wider.

## Timing
- Reset values:
  - `tx_o`=1.
  - `s_axi_awready_o`, `s_axi_wready_o`, `s_axi_bvalid_o`, `s_axi_arready_o`, `s_axi_rvalid_o` = 0.
  - `s_axi_bresp_o`=00, `s_axi_rresp_o`=00, `s_axi_rdata_o`=0.
  - FIFO empty; FSM in IDLE.
- Reset mid-frame aborts the frame: `tx_o`=1 from the cycle after `rst_i` is sampled, and FIFO contents are lost.
- Write latency:
  - Handshake at cycle N → `bvalid_o`=1 at N+1, held until `bready_i`.
  - `bvalid_o` falls the cycle after `bvalid_o`&&`bready_i`.
  - Next AW/W acceptance is no earlier than that cycle.
- Read latency: handshake at N → `rvalid_o`=1 with `rdata_o` at N+1, held stable until `rready_i`.
- Push to line: push at N (FSM in IDLE) → pop at N+1 → `tx_o`=0 from N+2.
- Frame length: exactly `10*CLKS_PER_BIT` cycles. Back-to-back frames from a non-empty FIFO have zero idle cycles between the stop bit and the next start bit.
- STATUS reflects registered FIFO state at the AR handshake cycle. A push at cycle N is visible to a read handshake at N+1 or later.
- Throughput: at most one register write per 2 cycles (handshake, then B).

## Test plan
- Reset with `CLKS_PER_BIT`=4, then read 0x8 → `rdata`=0x00000004, `rresp`=00; `tx_o` stays 1 for 100 cycles.
- Write 0x4 data 0xA5 → `tx_o` low 4 cycles starting 2 cycles after handshake. Then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high 4 cycles. Total 40 cycles.
- Write 0x41, 0x42, 0x43 back-to-back, with `bready` held high → three contiguous 40-cycle frames with no gap; STATUS bit2=1 after the third pop.
- `FIFO_DEPTH`=4, 6 writes while the first frame is in flight → STATUS=0x08 after the 5th write; 6th byte dropped with `bresp`=00; exactly 5 frames emitted.
- Write CTRL=0x1 during the first of 3 queued frames → the current frame completes, no further frames, STATUS=0x04.
- AW valid 3 cycles before W; `bready` low for 5 cycles; `rready` stalled on a read → no acceptance until both AW and W are valid, `bvalid` held, `rdata` stable. Assert `rst_i` mid-frame → `tx_o`=1 next cycle, all valids 0.
